// File: rtl/cv32e40p_pkg.sv
// Shared types for the cv32e40p core slice: sleep controller state encoding
// and a small elaboration-time helper.
package cv32e40p_pkg;

  typedef enum logic [2:0] {
    SLP_IDLE,
    SLP_RUN,
    SLP_DRAIN,
    SLP_SLEEP,
    SLP_WAKE
  } sleep_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cv32e40p_sleep_ctrl.sv
// Sleep / clock-enable controller for the core clock gate. Runs on the
// free-running clock, keeps the core clock off until fetch is enabled,
// drains fetch/LSU activity on WFI before gating, and wakes on irq/debug.
module cv32e40p_sleep_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int unsigned MIN_IDLE    = 2,
  parameter int unsigned WAKE_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic fetch_enable_i,
  input  logic wfi_req_i,
  input  logic if_busy_i,
  input  logic lsu_busy_i,
  input  logic irq_pending_i,
  input  logic debug_req_i,
  output logic clock_en_o,
  output logic core_sleep_o
);

  localparam int unsigned CNT_W = $clog2(max_u(MIN_IDLE, WAKE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(MIN_IDLE - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  sleep_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clock_en_d, core_sleep_d;
  logic             wake_req, idle;

  assign wake_req = irq_pending_i | debug_req_i;
  assign idle     = ~if_busy_i & ~lsu_busy_i;

  // State register, shared idle/wake counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= SLP_IDLE;
      cnt_q        <= '0;
      clock_en_o   <= 1'b0;
      core_sleep_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clock_en_o   <= clock_en_d;
      core_sleep_o <= core_sleep_d;
    end
  end

  // Next-state and counter logic; outputs are decoded from the next state
  // so the registered outputs line up with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SLP_IDLE: begin
        if (fetch_enable_i) state_d = SLP_RUN;
      end
      SLP_RUN: begin
        if (wfi_req_i && !wake_req) state_d = SLP_DRAIN;
      end
      SLP_DRAIN: begin
        if (wake_req || !wfi_req_i) begin
          state_d = SLP_RUN;
          cnt_d   = '0;
        end else if (!idle) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = SLP_SLEEP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SLP_SLEEP: begin
        if (wake_req) state_d = SLP_WAKE;
      end
      SLP_WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = SLP_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = SLP_IDLE;
        cnt_d   = '0;
      end
    endcase

    clock_en_d   = (state_d == SLP_RUN) || (state_d == SLP_DRAIN) || (state_d == SLP_WAKE);
    core_sleep_d = (state_d == SLP_SLEEP) || (state_d == SLP_WAKE);
  end

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl.sv
// Self-checking bench for cv32e40p_sleep_ctrl: table-driven vectors with a
// scoreboard queue, plus hand-written async-reset and parameter sequences.
module tb_cv32e40p_sleep_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic fetch_enable, wfi_req, if_busy, lsu_busy, irq_pending, debug_req;
  logic clock_en, core_sleep;
  logic clock_en2, core_sleep2;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned vec_idx = 0;

  typedef struct {
    logic fe, wfi, ifb, lsb, irq, dbg;
    logic ce, sl;
    logic c2, ce2, sl2;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  cv32e40p_sleep_ctrl #(.MIN_IDLE(2), .WAKE_CYCLES(1)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .fetch_enable_i (fetch_enable),
    .wfi_req_i      (wfi_req),
    .if_busy_i      (if_busy),
    .lsu_busy_i     (lsu_busy),
    .irq_pending_i  (irq_pending),
    .debug_req_i    (debug_req),
    .clock_en_o     (clock_en),
    .core_sleep_o   (core_sleep)
  );

  cv32e40p_sleep_ctrl #(.MIN_IDLE(3), .WAKE_CYCLES(2)) dut2 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .fetch_enable_i (fetch_enable),
    .wfi_req_i      (wfi_req),
    .if_busy_i      (if_busy),
    .lsu_busy_i     (lsu_busy),
    .irq_pending_i  (irq_pending),
    .debug_req_i    (debug_req),
    .clock_en_o     (clock_en2),
    .core_sleep_o   (core_sleep2)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic add(input int unsigned n,
                     input logic fe, input logic wfi, input logic ifb, input logic lsb,
                     input logic irq, input logic dbg, input logic ce, input logic sl);
    vec_t v;
    v = '{fe: fe, wfi: wfi, ifb: ifb, lsb: lsb, irq: irq, dbg: dbg,
          ce: ce, sl: sl, c2: 1'b0, ce2: 1'b0, sl2: 1'b0};
    repeat (n) tbl.push_back(v);
  endtask

  function automatic vec_t mk2(input logic fe, input logic wfi, input logic irq,
                               input logic ce, input logic sl, input logic ce2, input logic sl2);
    vec_t v;
    v = '{fe: fe, wfi: wfi, ifb: 1'b0, lsb: 1'b0, irq: irq, dbg: 1'b0,
          ce: ce, sl: sl, c2: 1'b1, ce2: ce2, sl2: sl2};
    return v;
  endfunction

  // Drive one vector, let one rising edge sample it, compare #1 later.
  task automatic step(input vec_t v);
    vec_t e;
    fetch_enable = v.fe;
    wfi_req      = v.wfi;
    if_busy      = v.ifb;
    lsu_busy     = v.lsb;
    irq_pending  = v.irq;
    debug_req    = v.dbg;
    sb.push_back(v);
    @(posedge clk);
    #1;
    vec_idx++;
    e = sb.pop_front();
    chk($sformatf("vec%0d clock_en", vec_idx), clock_en, e.ce);
    chk($sformatf("vec%0d core_sleep", vec_idx), core_sleep, e.sl);
    if (e.c2) begin
      chk($sformatf("vec%0d dut2 clock_en", vec_idx), clock_en2, e.ce2);
      chk($sformatf("vec%0d dut2 core_sleep", vec_idx), core_sleep2, e.sl2);
    end
  endtask

  // Assert reset between edges and check outputs clear without a clock edge.
  task automatic async_reset(input string nm);
    #2 rst_n = 1'b0;
    #1;
    chk({nm, " clock_en"}, clock_en, 1'b0);
    chk({nm, " core_sleep"}, core_sleep, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    fetch_enable = 1'b0; wfi_req = 1'b0; if_busy = 1'b0;
    lsu_busy = 1'b0; irq_pending = 1'b0; debug_req = 1'b0;

    // Row k is sampled at edge k (edges counted from reset release).
    //   n   fe wfi ifb lsb irq dbg  ce sl
    add(4,   0, 0,  0,  0,  0,  0,   0, 0);  // edges 1-4: clock held off
    add(5,   1, 0,  0,  0,  0,  0,   1, 0);  // edge 5: start
    add(10,  0, 0,  0,  0,  0,  0,   1, 0);  // edge 10+: fetch_enable dropped, ignored
    add(2,   0, 1,  0,  0,  0,  0,   1, 0);  // edge 20-21: DRAIN
    add(3,   0, 1,  0,  0,  0,  0,   0, 1);  // edge 22: SLEEP
    add(3,   0, 1,  1,  1,  0,  0,   0, 1);  // busy ignored in SLEEP
    add(12,  0, 1,  0,  0,  0,  0,   0, 1);
    add(1,   0, 1,  0,  0,  1,  0,   1, 1);  // edge 40: irq -> WAKE
    add(1,   0, 0,  0,  0,  0,  0,   1, 0);  // edge 41: RUN, irq already dropped
    add(8,   0, 0,  0,  0,  0,  0,   1, 0);
    add(1,   0, 1,  0,  0,  0,  0,   1, 0);  // edge 50: DRAIN
    add(3,   0, 1,  0,  1,  0,  0,   1, 0);  // edges 51-53: lsu busy
    add(1,   0, 1,  0,  0,  0,  0,   1, 0);  // edge 54: first idle
    add(3,   0, 1,  0,  0,  0,  0,   0, 1);  // edge 55: SLEEP
    add(1,   0, 0,  0,  0,  0,  1,   1, 1);  // debug -> WAKE
    add(3,   0, 0,  0,  0,  0,  0,   1, 0);  // RUN
    add(1,   0, 1,  0,  0,  0,  0,   1, 0);  // DRAIN
    add(1,   0, 1,  0,  0,  0,  0,   1, 0);  // idle cnt 1
    add(1,   0, 1,  0,  0,  0,  1,   1, 0);  // terminal cycle + debug -> RUN
    add(2,   0, 1,  0,  0,  0,  1,   1, 0);  // wfi & wake in RUN: stay RUN
    add(1,   0, 1,  0,  0,  1,  0,   1, 0);  // same with irq
    add(1,   0, 1,  0,  0,  0,  0,   1, 0);  // DRAIN
    add(1,   0, 1,  1,  0,  0,  0,   1, 0);  // fetch busy
    add(1,   0, 0,  0,  0,  0,  0,   1, 0);  // wfi dropped -> RUN
    add(2,   0, 0,  0,  0,  0,  0,   1, 0);
    add(2,   0, 1,  0,  0,  0,  0,   1, 0);  // fresh DRAIN, full count again
    add(1,   0, 1,  0,  0,  0,  0,   0, 1);  // SLEEP
    add(1,   0, 0,  0,  0,  1,  0,   1, 1);  // WAKE

    #12;
    chk("reset clock_en", clock_en, 1'b0);
    chk("reset core_sleep", core_sleep, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // Reset while in WAKE, then restart must wait for fetch_enable.
    async_reset("rst in WAKE");
    step(mk2(0, 1, 1, 0, 0, 0, 0));
    step(mk2(0, 1, 1, 0, 0, 0, 0));
    step(mk2(1, 0, 0, 1, 0, 1, 0));
    step(mk2(0, 1, 0, 1, 0, 1, 0));
    step(mk2(0, 1, 0, 1, 0, 1, 0));
    step(mk2(0, 1, 0, 0, 1, 1, 0));  // dut1 SLEEP, dut2 still draining

    // Reset while in SLEEP.
    async_reset("rst in SLEEP");
    step(mk2(0, 1, 1, 0, 0, 0, 0));

    // Longer idle window and wake latency on the second instance.
    step(mk2(1, 0, 0, 1, 0, 1, 0));
    step(mk2(0, 1, 0, 1, 0, 1, 0));
    step(mk2(0, 1, 0, 1, 0, 1, 0));
    step(mk2(0, 1, 0, 0, 1, 1, 0));
    step(mk2(0, 1, 0, 0, 1, 0, 1));
    step(mk2(0, 1, 0, 0, 1, 0, 1));
    step(mk2(0, 0, 1, 1, 1, 1, 1));
    step(mk2(0, 0, 0, 1, 0, 1, 1));
    step(mk2(0, 0, 0, 1, 0, 1, 0));
    step(mk2(0, 0, 0, 1, 0, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40p_sleep_ctrl.md
# cv32e40p_sleep_ctrl

Sleep/clock-enable controller that drives the enable input of the core clock-gating cell. It runs on the free-running clock and holds the core clock off until fetch is enabled. On a WFI it drains outstanding instruction-fetch and LSU activity, then gates the core clock. It re-enables the clock on an interrupt or debug request.

## Interface
Parameters:
- MIN_IDLE, 2: consecutive idle DRAIN cycles required before sleeping; range ≥1.
- WAKE_CYCLES, 1: cycles the clock runs in WAKE before core_sleep_o drops; range ≥1.

Ports:
- clk_i  in  1  free-running (ungated) clock; one clock domain only.
- rst_ni  in  1  reset; asynchronous, active-low.
- fetch_enable_i  in  1  core start request; sticky once sampled high.
- wfi_req_i  in  1  core stalled on WFI; held high by the core while it wants to sleep.
- if_busy_i  in  1  instruction fetch has outstanding transactions.
- lsu_busy_i  in  1  LSU has outstanding transactions.
- irq_pending_i  in  1  enabled interrupt pending (level).
- debug_req_i  in  1  external debug request (level).
- clock_en_o  out  1  enable for the core clock gate; registered.
- core_sleep_o  out  1  core is asleep or waking; registered.

## Operation
- wake_req = irq_pending_i | debug_req_i.
- idle = !if_busy_i & !lsu_busy_i.
- Five states; all outputs are registered and decoded from the next state.
- IDLE (reset state): clock_en_o=0, core_sleep_o=0.
  - fetch_enable_i=1 → RUN.
- RUN: clock_en_o=1, core_sleep_o=0.
  - wfi_req_i & !wake_req → DRAIN.
  - After leaving IDLE, fetch_enable_i is ignored; deasserting it never stops the clock.
- DRAIN: clock_en_o=1, core_sleep_o=0. Idle counter cnt counts consecutive idle DRAIN cycles.
  - Priority, highest first:
    1. wake_req | !wfi_req_i → RUN; cnt=0.
    2. !idle → cnt=0; stay in DRAIN.
    3. idle & cnt==MIN_IDLE-1 → SLEEP; cnt=0.
    4. otherwise cnt+1; stay in DRAIN.
- SLEEP: clock_en_o=0, core_sleep_o=1.
  - wake_req → WAKE.
  - Busy inputs and wfi_req_i are ignored.
- WAKE: clock_en_o=1, core_sleep_o=1. The same counter counts WAKE cycles.
  - cnt==WAKE_CYCLES-1 → RUN; cnt=0.
  - otherwise cnt+1.
  - wake_req may drop during WAKE; the return to RUN still happens.
- Counter:
  - Width $clog2(max(MIN_IDLE,WAKE_CYCLES)+1).
  - Cleared on every state change.
  - Never wraps: the state exits at the terminal value.
- Asynchronous reset, mid-operation included: state IDLE, cnt=0, clock_en_o=0, core_sleep_o=0, all immediately.
  - The core must see fetch_enable_i again before its clock restarts.

## Timing
- Edge n means the nth rising edge of clk_i. An input "sampled at edge n" was high during the cycle before edge n.
- Start: fetch_enable_i sampled at edge n → clock_en_o=1 after edge n.
- Entering sleep, always idle, MIN_IDLE=M: wfi_req_i sampled at edge n → DRAIN after edge n → clock_en_o=0 and core_sleep_o=1 after edge n+M.
- Busy during DRAIN restarts the M-cycle count from the first idle cycle after it.
- Wake: wake_req sampled at edge k while in SLEEP → clock_en_o=1 after edge k → core_sleep_o=0 after edge k+WAKE_CYCLES.
- wake_req and wfi_req_i both high in RUN: stay in RUN (wake wins).
- wake_req in the same cycle DRAIN would otherwise enter SLEEP: → RUN; clock_en_o never drops.
- No combinational path from any input to any output.

## Structure
- Shared package cv32e40p_pkg holds the state enum sleep_state_e: SLP_IDLE, SLP_RUN, SLP_DRAIN, SLP_SLEEP, SLP_WAKE.
- clock_en_o connects directly to the gate's en_i; the gating cell stays a separate instance in the parent.
- No sub-module: one state register, one counter and an output decode.

## Test plan
- Reset, then fetch_enable_i=1 at edge 5 → clock_en_o 0 through edge 4, 1 after edge 5; core_sleep_o stays 0; dropping fetch_enable_i at edge 10 has no effect.
- MIN_IDLE=2, idle, wfi_req_i sampled at edge 20 → clock_en_o=0 and core_sleep_o=1 after edge 22.
- Same, with lsu_busy_i high for cycles ending at edges 21–23 → SLEEP after edge 25.
- In SLEEP, irq_pending_i sampled at edge 40, WAKE_CYCLES=1 → clock_en_o=1 after edge 40, core_sleep_o=0 after edge 41; repeat with debug_req_i, same result.
- DRAIN abort: debug_req_i at the terminal idle cycle → RUN; clock_en_o stays 1 throughout. wfi_req_i dropped mid-DRAIN → RUN.
- rst_ni asserted asynchronously in SLEEP and in WAKE → clock_en_o=0, core_sleep_o=0 at once; restart needs fetch_enable_i.
